// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the single-port data memory.
// The arbiter uses the slave modport; the requester/memory side uses master.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dma_req;
    logic              dma_we;
    logic              dma_lock;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_addr, mem_wdata, mem_read, mem_write,
        output busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_addr, mem_wdata, mem_read, mem_write,
        input  busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// CPU/DMA arbiter and sequencer for the single-port data memory: one access in flight,
// CPU priority with DMA starvation relief and DMA bus-lock, all outputs registered.
module dmem_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 16,
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 4
) (
    input logic          clk,
    input logic          reset,
    dmem_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT  = 2'd1;
    localparam logic [1:0] RDWAIT = 2'd2;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [2:0] LAT_INIT   = 3'(RD_LATENCY);

    logic [1:0]        state_q, state_d;
    logic              owner_dma_q, owner_dma_d;
    logic              we_q, we_d;
    logic [3:0]        starve_q, starve_d;
    logic              lock_q, lock_d;
    logic [2:0]        lat_q, lat_d;
    logic              cpu_gnt_q, cpu_gnt_d;
    logic              dma_gnt_q, dma_gnt_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic              dma_rvalid_q, dma_rvalid_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
    logic              busy_q, busy_d;

    logic cpu_win, dma_win;

    // Lock masks the CPU entirely; a starved DMA pre-empts it; otherwise CPU has priority.
    always_comb begin
        cpu_win = bus.cpu_req && !lock_q && !(bus.dma_req && (starve_q == STARVE_MAX));
        dma_win = bus.dma_req && !cpu_win;
    end

    always_comb begin
        state_d      = state_q;
        owner_dma_d  = owner_dma_q;
        we_d         = we_q;
        starve_d     = starve_q;
        lock_d       = lock_q;
        lat_d        = lat_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        dma_rdata_d  = dma_rdata_q;
        cpu_gnt_d    = 1'b0;
        dma_gnt_d    = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        cpu_rvalid_d = 1'b0;
        dma_rvalid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!bus.dma_req) begin
                    starve_d = '0;
                    lock_d   = 1'b0;
                end
                if (cpu_win) begin
                    state_d     = GRANT;
                    owner_dma_d = 1'b0;
                    we_d        = bus.cpu_we;
                    mem_addr_d  = bus.cpu_addr;
                    mem_wdata_d = bus.cpu_wdata;
                    cpu_gnt_d   = 1'b1;
                    mem_write_d = bus.cpu_we;
                    mem_read_d  = !bus.cpu_we;
                    if (bus.dma_req && (starve_q != STARVE_MAX))
                        starve_d = starve_q + 4'd1;
                end else if (dma_win) begin
                    state_d     = GRANT;
                    owner_dma_d = 1'b1;
                    we_d        = bus.dma_we;
                    mem_addr_d  = bus.dma_addr;
                    mem_wdata_d = bus.dma_wdata;
                    dma_gnt_d   = 1'b1;
                    mem_write_d = bus.dma_we;
                    mem_read_d  = !bus.dma_we;
                    starve_d    = '0;
                    lock_d      = bus.dma_lock;
                end
            end
            GRANT: begin
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = RDWAIT;
                    lat_d   = LAT_INIT;
                end
            end
            RDWAIT: begin
                lat_d = lat_q - 3'd1;
                if (lat_q == 3'd1) begin
                    state_d = IDLE;
                    if (owner_dma_q) begin
                        dma_rdata_d  = bus.mem_rdata;
                        dma_rvalid_d = 1'b1;
                    end else begin
                        cpu_rdata_d  = bus.mem_rdata;
                        cpu_rvalid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_dma_q  <= 1'b0;
            we_q         <= 1'b0;
            starve_q     <= '0;
            lock_q       <= 1'b0;
            lat_q        <= '0;
            cpu_gnt_q    <= 1'b0;
            dma_gnt_q    <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_dma_q  <= owner_dma_d;
            we_q         <= we_d;
            starve_q     <= starve_d;
            lock_q       <= lock_d;
            lat_q        <= lat_d;
            cpu_gnt_q    <= cpu_gnt_d;
            dma_gnt_q    <= dma_gnt_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dma_rvalid_q <= dma_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.cpu_gnt    = cpu_gnt_q;
    assign bus.dma_gnt    = dma_gnt_q;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.dma_rvalid = dma_rvalid_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.dma_rdata  = dma_rdata_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with RD_LATENCY=2, STARVE_LIMIT=4; memory read data
// is driven directly by the bench. Inputs change and outputs are sampled 1 ns after posedge.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    dmem_arbiter #(
        .ADDR_W(8), .DATA_W(16), .RD_LATENCY(2), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_lock = 1'b0;
        bus.dma_addr = '0; bus.dma_wdata = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        bus.mem_rdata = 16'h0;
        tick(); tick();
        n_checks++; if ({bus.cpu_gnt, bus.dma_gnt} !== 2'b00) begin n_fail++;
            $display("FAIL reset_gnt: got %b expected 00", {bus.cpu_gnt, bus.dma_gnt}); end
        n_checks++; if ({bus.mem_read, bus.mem_write} !== 2'b00) begin n_fail++;
            $display("FAIL reset_strobe: got %b expected 00", {bus.mem_read, bus.mem_write}); end
        n_checks++; if ({bus.cpu_rvalid, bus.dma_rvalid, bus.busy} !== 3'b000) begin n_fail++;
            $display("FAIL reset_valid_busy: got %b expected 000", {bus.cpu_rvalid, bus.dma_rvalid, bus.busy}); end
        n_checks++; if ({bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.dma_rdata} !== 56'h0) begin n_fail++;
            $display("FAIL reset_data: got %h expected 0", {bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.dma_rdata}); end
        reset = 1'b0;
        tick();
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++;
            $display("FAIL reset_idle_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_cpu_write();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h12; bus.cpu_wdata = 16'hBEEF;
        tick();
        n_checks++; if ({bus.cpu_gnt, bus.dma_gnt, bus.mem_write, bus.mem_read, bus.busy} !== 5'b10101) begin n_fail++;
            $display("FAIL cpu_write_strobes: got %b expected 10101", {bus.cpu_gnt, bus.dma_gnt, bus.mem_write, bus.mem_read, bus.busy}); end
        n_checks++; if ({bus.mem_addr, bus.mem_wdata} !== 24'h12BEEF) begin n_fail++;
            $display("FAIL cpu_write_addr_data: got %h expected 12beef", {bus.mem_addr, bus.mem_wdata}); end
        bus.cpu_req = 1'b0;
        tick();
        n_checks++; if ({bus.busy, bus.cpu_gnt, bus.mem_write} !== 3'b000) begin n_fail++;
            $display("FAIL cpu_write_done: got %b expected 000", {bus.busy, bus.cpu_gnt, bus.mem_write}); end
        n_checks++; if ({bus.mem_addr, bus.mem_wdata} !== 24'h12BEEF) begin n_fail++;
            $display("FAIL cpu_write_hold: got %h expected 12beef", {bus.mem_addr, bus.mem_wdata}); end
    endtask

    task automatic test_dma_read();
        bus.mem_rdata = 16'h1234;
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 8'h40;
        tick();
        n_checks++; if ({bus.dma_gnt, bus.cpu_gnt, bus.mem_read, bus.mem_write} !== 4'b1010) begin n_fail++;
            $display("FAIL dma_read_grant: got %b expected 1010", {bus.dma_gnt, bus.cpu_gnt, bus.mem_read, bus.mem_write}); end
        n_checks++; if (bus.mem_addr !== 8'h40) begin n_fail++;
            $display("FAIL dma_read_addr: got %h expected 40", bus.mem_addr); end
        bus.dma_req = 1'b0;
        tick();
        n_checks++; if ({bus.mem_read, bus.dma_rvalid, bus.busy} !== 3'b001) begin n_fail++;
            $display("FAIL dma_read_wait1: got %b expected 001", {bus.mem_read, bus.dma_rvalid, bus.busy}); end
        tick();
        n_checks++; if ({bus.dma_rvalid, bus.busy} !== 2'b01) begin n_fail++;
            $display("FAIL dma_read_wait2: got %b expected 01", {bus.dma_rvalid, bus.busy}); end
        tick();
        n_checks++; if ({bus.dma_rvalid, bus.cpu_rvalid, bus.busy} !== 3'b100) begin n_fail++;
            $display("FAIL dma_read_valid: got %b expected 100", {bus.dma_rvalid, bus.cpu_rvalid, bus.busy}); end
        n_checks++; if (bus.dma_rdata !== 16'h1234) begin n_fail++;
            $display("FAIL dma_read_data: got %h expected 1234", bus.dma_rdata); end
        tick();
        n_checks++; if ({bus.dma_rvalid, bus.dma_rdata} !== {1'b0, 16'h1234}) begin n_fail++;
            $display("FAIL dma_read_after: got %b/%h expected 0/1234", bus.dma_rvalid, bus.dma_rdata); end
    endtask

    task automatic test_back_to_back();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h01; bus.cpu_wdata = 16'h0101;
        tick();
        n_checks++; if ({bus.cpu_gnt, bus.mem_addr} !== {1'b1, 8'h01}) begin n_fail++;
            $display("FAIL b2b_first: got %b/%h expected 1/01", bus.cpu_gnt, bus.mem_addr); end
        bus.cpu_addr = 8'h02; bus.cpu_wdata = 16'h0202;
        tick();
        n_checks++; if ({bus.cpu_gnt, bus.mem_write} !== 2'b00) begin n_fail++;
            $display("FAIL b2b_gap: got %b expected 00", {bus.cpu_gnt, bus.mem_write}); end
        tick();
        n_checks++; if ({bus.cpu_gnt, bus.mem_write, bus.mem_addr, bus.mem_wdata} !== {2'b11, 8'h02, 16'h0202}) begin n_fail++;
            $display("FAIL b2b_second: got %b%b/%h/%h expected 11/02/0202", bus.cpu_gnt, bus.mem_write, bus.mem_addr, bus.mem_wdata); end
        // next: CPU read, DMA write waiting behind it, sampled in the rvalid cycle
        bus.cpu_we = 1'b0; bus.cpu_addr = 8'h60; bus.mem_rdata = 16'h6060;
        tick(); tick();
        n_checks++; if ({bus.cpu_gnt, bus.mem_read} !== 2'b11) begin n_fail++;
            $display("FAIL b2b_read_grant: got %b expected 11", {bus.cpu_gnt, bus.mem_read}); end
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 8'h70; bus.dma_wdata = 16'h7070;
        tick(); tick();
        n_checks++; if (bus.dma_gnt !== 1'b0) begin n_fail++;
            $display("FAIL b2b_no_gnt_rdwait: got %b expected 0", bus.dma_gnt); end
        tick();
        n_checks++; if ({bus.cpu_rvalid, bus.cpu_rdata, bus.dma_gnt} !== {1'b1, 16'h6060, 1'b0}) begin n_fail++;
            $display("FAIL b2b_rvalid: got %b/%h/%b expected 1/6060/0", bus.cpu_rvalid, bus.cpu_rdata, bus.dma_gnt); end
        tick();
        n_checks++; if ({bus.dma_gnt, bus.mem_write, bus.mem_addr} !== {2'b11, 8'h70}) begin n_fail++;
            $display("FAIL b2b_overlap_gnt: got %b%b/%h expected 11/70", bus.dma_gnt, bus.mem_write, bus.mem_addr); end
        bus.dma_req = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        logic [9:0] seq;
        int ng;
        bit clash;
        seq = '0; ng = 0; clash = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h10; bus.cpu_wdata = 16'h1010;
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_lock = 1'b0; bus.dma_addr = 8'h20; bus.dma_wdata = 16'h2020;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (bus.cpu_gnt && bus.dma_gnt) clash = 1'b1;
            if (bus.mem_read && bus.mem_write) clash = 1'b1;
            if (bus.cpu_gnt || bus.dma_gnt) begin
                if (ng < 10) seq[ng] = bus.dma_gnt;
                ng++;
            end
        end
        idle_inputs();
        tick();
        n_checks++; if (ng !== 10) begin n_fail++;
            $display("FAIL starve_count: got %0d grants expected 10", ng); end
        n_checks++; if (seq !== 10'b1000010000) begin n_fail++;
            $display("FAIL starve_pattern: got %b expected 1000010000 (bit0 first, 1=DMA)", seq); end
        n_checks++; if (clash !== 1'b0) begin n_fail++;
            $display("FAIL starve_exclusive: got %b expected 0", clash); end
    endtask

    task automatic test_lock();
        bit got_cpu, got_dma;
        got_cpu = 1'b0; got_dma = 1'b0;
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_lock = 1'b1; bus.dma_addr = 8'h80; bus.dma_wdata = 16'h8080;
        tick();
        n_checks++; if ({bus.dma_gnt, bus.cpu_gnt} !== 2'b10) begin n_fail++;
            $display("FAIL lock_first: got %b expected 10", {bus.dma_gnt, bus.cpu_gnt}); end
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h03; bus.cpu_wdata = 16'h0303;
        for (int i = 0; i < 3; i++) begin
            tick();
            tick();
            n_checks++; if ({bus.dma_gnt, bus.cpu_gnt} !== 2'b10) begin n_fail++;
                $display("FAIL lock_hold_%0d: got %b expected 10", i, {bus.dma_gnt, bus.cpu_gnt}); end
        end
        bus.dma_req = 1'b0; bus.dma_lock = 1'b0;
        for (int t = 0; t < 4 && !got_cpu; t++) begin
            tick();
            if (bus.dma_gnt) got_dma = 1'b1;
            if (bus.cpu_gnt) got_cpu = 1'b1;
        end
        n_checks++; if ({got_cpu, got_dma} !== 2'b10) begin n_fail++;
            $display("FAIL lock_release: got cpu=%b dma=%b expected cpu=1 dma=0", got_cpu, got_dma); end
        bus.cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_data_hold();
        bit seen;
        seen = 1'b0;
        bus.mem_rdata = 16'hA5A5;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h50;
        tick();
        bus.cpu_req = 1'b0;
        tick(); tick(); tick();
        n_checks++; if ({bus.cpu_rvalid, bus.cpu_rdata} !== {1'b1, 16'hA5A5}) begin n_fail++;
            $display("FAIL hold_read: got %b/%h expected 1/a5a5", bus.cpu_rvalid, bus.cpu_rdata); end
        bus.mem_rdata = 16'hFFFF;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h50; bus.cpu_wdata = 16'h1111;
        tick();
        n_checks++; if ({bus.cpu_gnt, bus.mem_write, bus.mem_wdata} !== {2'b11, 16'h1111}) begin n_fail++;
            $display("FAIL hold_write: got %b%b/%h expected 11/1111", bus.cpu_gnt, bus.mem_write, bus.mem_wdata); end
        bus.cpu_req = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tick();
            if (bus.cpu_rvalid) seen = 1'b1;
        end
        n_checks++; if ({seen, bus.cpu_rdata} !== {1'b0, 16'hA5A5}) begin n_fail++;
            $display("FAIL hold_rdata: got rvalid_seen=%b rdata=%h expected 0/a5a5", seen, bus.cpu_rdata); end
    endtask

    task automatic test_reset_mid_read();
        bit seen;
        seen = 1'b0;
        bus.mem_rdata = 16'h5555;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h33;
        tick();
        n_checks++; if (bus.mem_read !== 1'b1) begin n_fail++;
            $display("FAIL rst_mid_read_strobe: got %b expected 1", bus.mem_read); end
        bus.cpu_req = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        n_checks++; if ({bus.busy, bus.cpu_gnt, bus.dma_gnt, bus.mem_read, bus.mem_write, bus.cpu_rvalid, bus.dma_rvalid} !== 7'b0) begin n_fail++;
            $display("FAIL rst_mid_ctrl: got %b expected 0000000", {bus.busy, bus.cpu_gnt, bus.dma_gnt, bus.mem_read, bus.mem_write, bus.cpu_rvalid, bus.dma_rvalid}); end
        n_checks++; if ({bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.dma_rdata} !== 56'h0) begin n_fail++;
            $display("FAIL rst_mid_data: got %h expected 0", {bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.dma_rdata}); end
        tick();
        reset = 1'b0;
        for (int t = 0; t < 5; t++) begin
            tick();
            if (bus.cpu_rvalid || bus.dma_rvalid) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++;
            $display("FAIL rst_mid_no_rvalid: got %b expected 0", seen); end
        bus.mem_rdata = 16'h7777;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h34;
        tick();
        n_checks++; if ({bus.cpu_gnt, bus.mem_read, bus.mem_addr} !== {2'b11, 8'h34}) begin n_fail++;
            $display("FAIL rst_new_grant: got %b%b/%h expected 11/34", bus.cpu_gnt, bus.mem_read, bus.mem_addr); end
        bus.cpu_req = 1'b0;
        tick(); tick(); tick();
        n_checks++; if ({bus.cpu_rvalid, bus.cpu_rdata} !== {1'b1, 16'h7777}) begin n_fail++;
            $display("FAIL rst_new_read: got %b/%h expected 1/7777", bus.cpu_rvalid, bus.cpu_rdata); end
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_dma_read();
        test_back_to_back();
        test_starvation();
        test_lock();
        test_data_hold();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end
endmodule
